// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter/sequencer for a shared 4:1 data mux with a registered valid/ready output.
// Define RR_MUX_BURST_LOCK_EN to add the 4-bit lock input that lets a granted source keep the grant.
module rr_mux_arbiter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
`ifdef RR_MUX_BURST_LOCK_EN
  input  logic [3:0]       lock,
`endif
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic             s1,
  output logic             s0,
  output logic [3:0]       gnt,
  output logic [3:0]       ack
);

  // Handshake: a word moves downstream on every rising edge where out_valid and
  // out_ready are both high; out_valid, y and gnt stay stable until that happens.

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       sel_q, sel_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             valid_q, valid_d;

  logic [WIDTH-1:0] data_arr [4];
  logic [2:0]       pick;
  logic             hold;

  // Returns {found, index} of the first set bit of m searching upward from p.
  function automatic logic [2:0] rr_pick(input logic [3:0] m, input logic [1:0] p);
    logic [1:0] idx;
    logic [2:0] r;
    r = 3'b000;
    for (int i = 0; i < 4; i++) begin
      idx = p + 2'(i);
      if (!r[2] && m[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  always_comb begin
    data_arr[0] = a;
    data_arr[1] = b;
    data_arr[2] = c;
    data_arr[3] = d;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    y_d     = y_q;
    valid_d = valid_q;
    pick    = 3'b000;
    hold    = 1'b0;

    case (state_q)
      IDLE: begin
        pick = rr_pick(req, ptr_q);
        if (!pick[2]) begin
          valid_d = 1'b0;
          gnt_d   = 4'b0000;
        end
      end
      BUSY: begin
        if (out_ready) begin
`ifdef RR_MUX_BURST_LOCK_EN
          hold = lock[sel_q] & req[sel_q];
`endif
          if (hold) begin
            y_d = data_arr[sel_q];
          end else begin
            // The source just served is masked so others get the next slot.
            ptr_d = sel_q + 2'd1;
            pick  = rr_pick(req & ~gnt_q, sel_q + 2'd1);
            if (!pick[2]) begin
              state_d = IDLE;
              valid_d = 1'b0;
              gnt_d   = 4'b0000;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        gnt_d   = 4'b0000;
      end
    endcase

    if (pick[2]) begin
      state_d = BUSY;
      valid_d = 1'b1;
      sel_d   = pick[1:0];
      gnt_d   = 4'b0001 << pick[1:0];
      y_d     = data_arr[pick[1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;
  assign y         = y_q;
  assign s1        = sel_q[1];
  assign s0        = sel_q[0];
  assign gnt       = gnt_q;
  assign ack       = {4{valid_q & out_ready}} & gnt_q;

endmodule
